// File: rtl/lnl_btn_conditioner.sv
// Pushbutton front end: polarity fix, 2-flop synchroniser, per-channel debounce,
// press pulses and a sticky one-hot mode word with lowest-index priority.
module lnl_btn_conditioner #(
  parameter int BUTTON_COUNT   = 4,
  parameter int DEBOUNCE       = 20,
  parameter bit BTN_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BUTTON_COUNT-1:0] btns_raw,
  output logic [BUTTON_COUNT-1:0] btns_clean,
  output logic [BUTTON_COUNT-1:0] btns_press,
  output logic [BUTTON_COUNT-1:0] mode,
  output logic                    mode_change
);

  logic [BUTTON_COUNT-1:0] w_in;
  logic [BUTTON_COUNT-1:0] r_s1;
  logic [BUTTON_COUNT-1:0] r_s2;
  logic [BUTTON_COUNT-1:0] r_clean;
  logic [BUTTON_COUNT-1:0] r_press;
  logic [BUTTON_COUNT-1:0] r_mode;
  logic                    r_mode_chg;
  logic [DEBOUNCE-1:0]     r_cnt [BUTTON_COUNT];
  logic [BUTTON_COUNT-1:0] w_sel;
  logic                    w_found;

  assign w_in = BTN_ACTIVE_LOW ? ~btns_raw : btns_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_in;
      r_s2 <= r_s1;
    end
  end

  // A level is accepted on the 2^DEBOUNCE-th consecutive cycle it differs from btns_clean.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clean <= '0;
      r_press <= '0;
      for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_press <= '0;
      for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
        if (r_s2[i] == r_clean[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == '1) begin
          r_clean[i] <= r_s2[i];
          r_press[i] <= r_s2[i];
          r_cnt[i]   <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + DEBOUNCE'(1);
        end
      end
    end
  end

  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < BUTTON_COUNT; i++) begin
      if (r_press[i] && !w_found) begin
        w_sel[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

  // Re-pressing the active mode clears it; any other press selects that mode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode     <= '0;
      r_mode_chg <= 1'b0;
    end else if (|r_press) begin
      r_mode     <= (r_mode == w_sel) ? '0 : w_sel;
      r_mode_chg <= 1'b1;
    end else begin
      r_mode_chg <= 1'b0;
    end
  end

  assign btns_clean  = r_clean;
  assign btns_press  = r_press;
  assign mode        = r_mode;
  assign mode_change = r_mode_chg;

endmodule

// File: tb/tb_lnl_btn_conditioner.sv
// Bench for lnl_btn_conditioner: an active-high and an active-low instance (DEBOUNCE=3)
// compared against a window-based behavioural model plus directed latency checks.
module tb_lnl_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw_a, raw_b;
  logic [3:0] a_clean, a_press, a_mode;
  logic [3:0] b_clean, b_press, b_mode;
  logic       a_chg, b_chg;
  int         n_tests = 0;
  int         n_fail  = 0;

  // Model: a level flips once the twice-delayed input has disagreed with it for 8 edges.
  logic [3:0] m_h     [2][10];
  logic [3:0] m_clean [2];
  logic [3:0] m_press [2];
  logic [3:0] m_mode  [2];
  logic       m_chg   [2];

  always #5 clk = ~clk;

  lnl_btn_conditioner #(.BUTTON_COUNT(4), .DEBOUNCE(3), .BTN_ACTIVE_LOW(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .btns_raw(raw_a), .btns_clean(a_clean),
    .btns_press(a_press), .mode(a_mode), .mode_change(a_chg));

  lnl_btn_conditioner #(.BUTTON_COUNT(4), .DEBOUNCE(3), .BTN_ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .btns_raw(raw_b), .btns_clean(b_clean),
    .btns_press(b_press), .mode(b_mode), .mode_change(b_chg));

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 10; k++) m_h[d][k] = '0;
      m_clean[d] = '0;
      m_press[d] = '0;
      m_mode[d]  = '0;
      m_chg[d]   = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    logic [3:0] nxt_press;
    logic       stable;
    int         lo;
    for (int k = 9; k > 0; k--) m_h[d][k] = m_h[d][k-1];
    m_h[d][0] = (d == 0) ? raw_a : ~raw_b;
    m_chg[d] = 1'b0;
    if (m_press[d] != 4'b0) begin
      lo = 0;
      for (int i = 3; i >= 0; i--) if (m_press[d][i]) lo = i;
      m_mode[d] = (m_mode[d] == (4'b0001 << lo)) ? 4'b0000 : (4'b0001 << lo);
      m_chg[d]  = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      stable = 1'b1;
      for (int j = 2; j < 10; j++) if (m_h[d][j][i] == m_clean[d][i]) stable = 1'b0;
      nxt_press[i] = stable && !m_clean[d][i];
      if (stable) m_clean[d][i] = ~m_clean[d][i];
    end
    m_press[d] = nxt_press;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw_a = 4'($urandom);
    raw_b = 4'($urandom);
    #1 rst = 1'b0;
    model_reset();
    #1;
    if ({a_clean, a_press, a_mode, a_chg, b_clean, b_press, b_mode, b_chg} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_async got=%h exp=0", {a_clean, a_press, a_mode, a_chg, b_clean, b_press, b_mode, b_chg});
    end
    n_tests++;
    repeat (3) @(negedge clk);
    if ({a_clean, a_press, a_mode, a_chg, b_clean, b_press, b_mode, b_chg} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_hold got=%h exp=0", {a_clean, a_press, a_mode, a_chg, b_clean, b_press, b_mode, b_chg});
    end
    n_tests++;
    raw_a = 4'h0;
    raw_b = 4'hF;
    rst = 1'b1;
    repeat (4) begin
      tick();
      if ({a_clean, a_press, a_mode, a_chg} !== {m_clean[0], m_press[0], m_mode[0], m_chg[0]}) begin
        n_fail++;
        $display("FAIL reset_release got=%h exp=%h", {a_clean, a_press, a_mode, a_chg}, {m_clean[0], m_press[0], m_mode[0], m_chg[0]});
      end
      n_tests++;
    end
  endtask

  task automatic test_press_latency();
    int rise = 0, pcnt = 0, pedge = 0, ccnt = 0, cedge = 0;
    raw_a = 4'b0001;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if ({a_clean, a_press, a_mode, a_chg} !== {m_clean[0], m_press[0], m_mode[0], m_chg[0]}) begin
        n_fail++;
        $display("FAIL latency_model e=%0d got=%h exp=%h", e, {a_clean, a_press, a_mode, a_chg}, {m_clean[0], m_press[0], m_mode[0], m_chg[0]});
      end
      n_tests++;
      if (a_clean[0] && rise == 0) rise = e;
      if (a_press != 4'b0) begin pcnt++; pedge = e; end
      if (a_chg) begin ccnt++; cedge = e; end
    end
    if (rise != 10) begin n_fail++; $display("FAIL latency_clean_edge got=%0d exp=10", rise); end
    n_tests++;
    if (pcnt != 1 || pedge != 10) begin n_fail++; $display("FAIL latency_press got=%0d@%0d exp=1@10", pcnt, pedge); end
    n_tests++;
    if (ccnt != 1 || cedge != 11) begin n_fail++; $display("FAIL latency_mode_change got=%0d@%0d exp=1@11", ccnt, cedge); end
    n_tests++;
    if (a_mode !== 4'b0001) begin n_fail++; $display("FAIL latency_mode got=%b exp=0001", a_mode); end
    n_tests++;
  endtask

  task automatic test_mode_toggle();
    logic [3:0] tv_raw  [5] = '{4'h0, 4'h1, 4'h0, 4'h4, 4'h0};
    logic [3:0] tv_mode [5] = '{4'h1, 4'h0, 4'h0, 4'h4, 4'h4};
    int         tv_p    [5] = '{0, 1, 0, 1, 0};
    int pcnt, ccnt;
    for (int s = 0; s < 5; s++) begin
      raw_a = tv_raw[s];
      pcnt = 0;
      ccnt = 0;
      repeat (14) begin
        tick();
        if ({a_clean, a_press, a_mode, a_chg} !== {m_clean[0], m_press[0], m_mode[0], m_chg[0]}) begin
          n_fail++;
          $display("FAIL toggle_model s=%0d got=%h exp=%h", s, {a_clean, a_press, a_mode, a_chg}, {m_clean[0], m_press[0], m_mode[0], m_chg[0]});
        end
        n_tests++;
        pcnt += $countones(a_press);
        ccnt += int'(a_chg);
      end
      if (a_mode !== tv_mode[s] || pcnt != tv_p[s] || ccnt != tv_p[s]) begin
        n_fail++;
        $display("FAIL toggle_step s=%0d mode=%b press=%0d chg=%0d exp mode=%b press=chg=%0d", s, a_mode, pcnt, ccnt, tv_mode[s], tv_p[s]);
      end
      n_tests++;
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] seen = 4'b0;
    int pc = 0;
    raw_a = 4'b1010;
    repeat (14) begin
      tick();
      if ({a_clean, a_press, a_mode, a_chg} !== {m_clean[0], m_press[0], m_mode[0], m_chg[0]}) begin
        n_fail++;
        $display("FAIL simul_model got=%h exp=%h", {a_clean, a_press, a_mode, a_chg}, {m_clean[0], m_press[0], m_mode[0], m_chg[0]});
      end
      n_tests++;
      if (a_press != 4'b0) begin seen = a_press; pc++; end
    end
    if (seen !== 4'b1010 || pc != 1) begin n_fail++; $display("FAIL simul_press got=%b x%0d exp=1010 x1", seen, pc); end
    n_tests++;
    if (a_mode !== 4'b0010 || a_clean !== 4'b1010) begin
      n_fail++;
      $display("FAIL simul_mode got mode=%b clean=%b exp mode=0010 clean=1010", a_mode, a_clean);
    end
    n_tests++;
    raw_a = 4'b0000;
    repeat (14) tick();
    if (a_clean !== 4'b0000) begin n_fail++; $display("FAIL simul_release got=%b exp=0000", a_clean); end
    n_tests++;
  endtask

  task automatic test_bounce();
    int rise = 0, pcnt = 0, w;
    for (int seg = 0; seg < 4; seg++) begin
      raw_a[1] = (seg % 2 == 0);
      w = $urandom_range(1, 6);
      repeat (w) begin
        tick();
        if (a_clean !== 4'b0000 || {a_clean, a_press, a_mode, a_chg} !== {m_clean[0], m_press[0], m_mode[0], m_chg[0]}) begin
          n_fail++;
          $display("FAIL bounce_hold got=%h exp=%h", {a_clean, a_press, a_mode, a_chg}, {m_clean[0], m_press[0], m_mode[0], m_chg[0]});
        end
        n_tests++;
      end
    end
    raw_a = 4'b0010;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if ({a_clean, a_press, a_mode, a_chg} !== {m_clean[0], m_press[0], m_mode[0], m_chg[0]}) begin
        n_fail++;
        $display("FAIL bounce_model e=%0d got=%h exp=%h", e, {a_clean, a_press, a_mode, a_chg}, {m_clean[0], m_press[0], m_mode[0], m_chg[0]});
      end
      n_tests++;
      if (a_clean[1] && rise == 0) rise = e;
      pcnt += int'(a_press[1]);
    end
    if (rise != 10 || pcnt != 1) begin n_fail++; $display("FAIL bounce_accept got=%0d pulses=%0d exp=10 pulses=1", rise, pcnt); end
    n_tests++;
    if (a_mode !== 4'b0000) begin n_fail++; $display("FAIL bounce_mode got=%b exp=0000", a_mode); end
    n_tests++;
    raw_a = 4'b0000;
    repeat (14) tick();
  endtask

  task automatic test_active_low();
    int rise = 0, fall = 0, pcnt = 0;
    raw_b = 4'b0111;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if ({b_clean, b_press, b_mode, b_chg} !== {m_clean[1], m_press[1], m_mode[1], m_chg[1]}) begin
        n_fail++;
        $display("FAIL actlow_model e=%0d got=%h exp=%h", e, {b_clean, b_press, b_mode, b_chg}, {m_clean[1], m_press[1], m_mode[1], m_chg[1]});
      end
      n_tests++;
      if (b_clean == 4'b1000 && rise == 0) rise = e;
    end
    if (rise != 10 || b_mode !== 4'b1000) begin n_fail++; $display("FAIL actlow_press edge=%0d mode=%b exp 10 1000", rise, b_mode); end
    n_tests++;
    raw_b = 4'b1111;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if ({b_clean, b_press, b_mode, b_chg} !== {m_clean[1], m_press[1], m_mode[1], m_chg[1]}) begin
        n_fail++;
        $display("FAIL actlow_rel_model e=%0d got=%h exp=%h", e, {b_clean, b_press, b_mode, b_chg}, {m_clean[1], m_press[1], m_mode[1], m_chg[1]});
      end
      n_tests++;
      if (b_clean == 4'b0000 && fall == 0) fall = e;
      pcnt += $countones(b_press);
    end
    if (fall != 10 || pcnt != 0 || b_mode !== 4'b1000) begin
      n_fail++;
      $display("FAIL actlow_release edge=%0d pulses=%0d mode=%b exp 10 0 1000", fall, pcnt, b_mode);
    end
    n_tests++;
  endtask

  task automatic test_reset_midcount();
    int rise = 0, pedge = 0, cedge = 0;
    raw_a = 4'b0100;
    repeat (14) tick();
    raw_a = 4'b0000;
    repeat (14) tick();
    if (a_mode !== 4'b0100) begin n_fail++; $display("FAIL midrst_setup got=%b exp=0100", a_mode); end
    n_tests++;
    raw_a = 4'b0100;
    repeat (7) tick();
    #2 rst = 1'b0;
    model_reset();
    #1;
    if ({a_clean, a_press, a_mode, a_chg, b_clean, b_press, b_mode, b_chg} !== 26'd0) begin
      n_fail++;
      $display("FAIL midrst_async got=%h exp=0", {a_clean, a_press, a_mode, a_chg, b_clean, b_press, b_mode, b_chg});
    end
    n_tests++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if ({a_clean, a_press, a_mode, a_chg} !== {m_clean[0], m_press[0], m_mode[0], m_chg[0]}) begin
        n_fail++;
        $display("FAIL midrst_model e=%0d got=%h exp=%h", e, {a_clean, a_press, a_mode, a_chg}, {m_clean[0], m_press[0], m_mode[0], m_chg[0]});
      end
      n_tests++;
      if (a_clean[2] && rise == 0) rise = e;
      if (a_press[2]) pedge = e;
      if (a_chg) cedge = e;
    end
    if (rise != 10 || pedge != 10 || cedge != 11 || a_mode !== 4'b0100) begin
      n_fail++;
      $display("FAIL midrst_repress clean@%0d press@%0d chg@%0d mode=%b exp 10 10 11 0100", rise, pedge, cedge, a_mode);
    end
    n_tests++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 5) == 0) raw_a[$urandom_range(0, 3)] = ~raw_a[$urandom_range(0, 3)];
      if ($urandom_range(0, 5) == 0) raw_b = raw_b ^ (4'b0001 << $urandom_range(0, 3));
      tick();
      if ({a_clean, a_press, a_mode, a_chg, b_clean, b_press, b_mode, b_chg} !==
          {m_clean[0], m_press[0], m_mode[0], m_chg[0], m_clean[1], m_press[1], m_mode[1], m_chg[1]}) begin
        n_fail++;
        $display("FAIL random_model c=%0d got=%h exp=%h", c, {a_clean, a_press, a_mode, a_chg, b_clean, b_press, b_mode, b_chg},
                 {m_clean[0], m_press[0], m_mode[0], m_chg[0], m_clean[1], m_press[1], m_mode[1], m_chg[1]});
      end
      n_tests++;
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_mode_toggle();
    test_simultaneous();
    test_bounce();
    test_active_low();
    test_reset_midcount();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
